// File: rtl/sweep_kw_gen_pkg.sv
// Shared definitions for the frequency-sweep controller: state encoding and default widths.
package sweep_kw_gen_pkg;

    localparam int DEF_KW_W     = 32;
    localparam int DEF_SETTLE_W = 24;
    localparam int DEF_IDX_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_MEAS   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/sweep_kw_gen_settle_timer.sv
// Loadable down-counter with a registered zero flag; load wins over enable.
// Counting stops at zero, so the flag stays set until the next load.
module settle_timer
    import sweep_kw_gen_pkg::*;
#(
    parameter int W = DEF_SETTLE_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;
    logic         r_zero;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_zero <= 1'b1;
        end else if (i_load) begin
            r_cnt  <= i_load_val;
            r_zero <= (i_load_val == '0);
        end else if (i_en && !r_zero) begin
            r_cnt  <= r_cnt - W'(1);
            r_zero <= (r_cnt == W'(1));
        end
    end

    assign o_zero = r_zero;

endmodule

// File: rtl/sweep_kw_gen.sv
// Steps the DDS tuning word through a programmed sweep, settling and handshaking one
// measurement per point; all outputs registered, Abort returns to IDLE in one cycle.
module sweep_kw_gen
    import sweep_kw_gen_pkg::*;
#(
    parameter int KW_W     = DEF_KW_W,
    parameter int SETTLE_W = DEF_SETTLE_W,
    parameter int IDX_W    = DEF_IDX_W
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                Start,
    input  logic                Abort,
    input  logic [KW_W-1:0]     KW_Start,
    input  logic [KW_W-1:0]     KW_Step,
    input  logic [IDX_W-1:0]    Step_Num,
    input  logic [SETTLE_W-1:0] Settle_Cycles,
    input  logic                Meas_Ack,
    output logic [KW_W-1:0]     KW,
    output logic                SW_Sin_Out,
    output logic                Meas_Req,
    output logic [IDX_W-1:0]    Point_Idx,
    output logic                Busy,
    output logic                Done
);

    state_t              r_state;
    logic [KW_W-1:0]     r_kw_step;
    logic [IDX_W-1:0]    r_step_num;
    logic [SETTLE_W-1:0] r_settle;

    logic                w_accept;
    logic                w_ack;
    logic                w_last;
    logic                w_advance;
    logic                w_tmr_load;
    logic [SETTLE_W-1:0] w_tmr_val;
    logic                w_tmr_en;
    logic                w_tmr_zero;

    assign w_accept   = (r_state == ST_IDLE) && Start && !Abort && (Step_Num != '0);
    assign w_ack      = Meas_Req && Meas_Ack;
    assign w_last     = (Point_Idx == r_step_num - IDX_W'(1));
    assign w_advance  = (r_state == ST_MEAS) && !Abort && w_ack && !w_last;
    assign w_tmr_load = w_accept || w_advance;
    // First point settles on the live input; later points reuse the latched copy.
    assign w_tmr_val  = (r_state == ST_IDLE) ? Settle_Cycles : r_settle;
    assign w_tmr_en   = (r_state == ST_SETTLE);

    settle_timer #(
        .W (SETTLE_W)
    ) u_settle_timer (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_kw_step  <= '0;
            r_step_num <= '0;
            r_settle   <= '0;
            KW         <= '0;
            SW_Sin_Out <= 1'b0;
            Meas_Req   <= 1'b0;
            Point_Idx  <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (r_state != ST_IDLE && Abort) begin
                r_state    <= ST_IDLE;
                KW         <= '0;
                SW_Sin_Out <= 1'b0;
                Meas_Req   <= 1'b0;
                Point_Idx  <= '0;
                Busy       <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_kw_step  <= KW_Step;
                            r_step_num <= Step_Num;
                            r_settle   <= Settle_Cycles;
                            KW         <= KW_Start;
                            Point_Idx  <= '0;
                            SW_Sin_Out <= 1'b1;
                            Busy       <= 1'b1;
                            r_state    <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (w_tmr_zero) begin
                            Meas_Req <= 1'b1;
                            r_state  <= ST_MEAS;
                        end
                    end
                    ST_MEAS: begin
                        if (w_ack) begin
                            Meas_Req <= 1'b0;
                            if (w_last) begin
                                KW         <= '0;
                                SW_Sin_Out <= 1'b0;
                                Point_Idx  <= '0;
                                Done       <= 1'b1;
                                r_state    <= ST_DONE;
                            end else begin
                                KW        <= KW + r_kw_step;
                                Point_Idx <= Point_Idx + IDX_W'(1);
                                r_state   <= ST_SETTLE;
                            end
                        end
                    end
                    ST_DONE: begin
                        Busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sweep_kw_gen.sv
// Directed bench for sweep_kw_gen: a point-level sweep model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_sweep_kw_gen;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Start = 1'b0;
    logic        Abort = 1'b0;
    logic [31:0] KW_Start = '0;
    logic [31:0] KW_Step = '0;
    logic [15:0] Step_Num = '0;
    logic [23:0] Settle_Cycles = '0;
    logic        Meas_Ack;
    logic [31:0] KW;
    logic        SW_Sin_Out;
    logic        Meas_Req;
    logic [15:0] Point_Idx;
    logic        Busy;
    logic        Done;

    int total = 0;
    int bad = 0;

    sweep_kw_gen #(.KW_W(32), .SETTLE_W(24), .IDX_W(16)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .Start         (Start),
        .Abort         (Abort),
        .KW_Start      (KW_Start),
        .KW_Step       (KW_Step),
        .Step_Num      (Step_Num),
        .Settle_Cycles (Settle_Cycles),
        .Meas_Ack      (Meas_Ack),
        .KW            (KW),
        .SW_Sin_Out    (SW_Sin_Out),
        .Meas_Req      (Meas_Req),
        .Point_Idx     (Point_Idx),
        .Busy          (Busy),
        .Done          (Done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Ack source: 0 = driven by the main thread, 1 = auto after ack_dly cycles of Req, 2 = tied high
    int   ack_mode = 0;
    int   ack_dly = 0;
    int   req_cnt = 0;
    logic man_ack = 1'b0;
    logic auto_ack = 1'b0;

    always_comb begin
        Meas_Ack = man_ack;
        if (ack_mode == 1) Meas_Ack = auto_ack;
        else if (ack_mode == 2) Meas_Ack = 1'b1;
    end

    always @(negedge CLK) begin
        if (Meas_Req) req_cnt++;
        else req_cnt = 0;
        auto_ack = Meas_Req && (req_cnt > ack_dly);
    end

    // Sweep model: a point index plus the settle cycles still owed (-1 = waiting for ack).
    logic        m_sweep = 1'b0;
    logic        m_done = 1'b0;
    int          m_left = 0;
    int          m_idx = 0;
    int          m_n = 0;
    int          m_s = 0;
    logic [31:0] m_k0 = '0;
    logic [31:0] m_step = '0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_sweep = 1'b0;
            m_done  = 1'b0;
            m_idx   = 0;
            m_left  = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_sweep) begin
            if (Abort) m_sweep = 1'b0;
            else if (m_left > 0) m_left--;
            else if (m_left == 0) m_left = -1;
            else if (Meas_Ack) begin
                if (m_idx == m_n - 1) begin
                    m_sweep = 1'b0;
                    m_done  = 1'b1;
                end else begin
                    m_idx++;
                    m_left = m_s;
                end
            end
        end else if (Start && !Abort && Step_Num != 16'd0) begin
            m_k0    = KW_Start;
            m_step  = KW_Step;
            m_n     = int'(Step_Num);
            m_s     = int'(Settle_Cycles);
            m_idx   = 0;
            m_left  = m_s;
            m_sweep = 1'b1;
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            check("kw", KW, m_sweep ? m_k0 + m_step * 32'(m_idx) : 32'h0);
            check("sin_en", 32'(SW_Sin_Out), 32'(m_sweep));
            check("req", 32'(Meas_Req), 32'(m_sweep && m_left < 0));
            check("busy", 32'(Busy), 32'(m_sweep || m_done));
            check("done", 32'(Done), 32'(m_done));
            if (!m_done) check("idx", 32'(Point_Idx), m_sweep ? 32'(m_idx) : 32'h0);
        end
    end

    logic        prev_req = 1'b0;
    logic [31:0] kw_log[$];
    int          n_done = 0;
    int          n_hs = 0;

    always @(negedge CLK) begin
        if (Meas_Req && !prev_req) kw_log.push_back(KW);
        if (Done) n_done++;
        prev_req = Meas_Req;
    end

    always @(posedge CLK) if (!RST && Meas_Req && Meas_Ack) n_hs++;

    task automatic start_sweep(input logic [31:0] k0, input logic [31:0] st,
                               input logic [15:0] n, input logic [23:0] s);
        KW_Start = k0;
        KW_Step = st;
        Step_Num = n;
        Settle_Cycles = s;
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (Busy && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check(name, 32'(Busy), 32'h0);
    endtask

    task automatic wait_req(input string name, input int budget);
        int n = 0;
        while (!Meas_Req && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check(name, 32'(Meas_Req), 32'h1);
    endtask

    int base_done;
    int base_hs;

    initial begin
        repeat (2) @(negedge CLK);
        check("rst_kw", KW, 32'h0);
        check("rst_sin", 32'(SW_Sin_Out), 32'h0);
        check("rst_req", 32'(Meas_Req), 32'h0);
        check("rst_idx", 32'(Point_Idx), 32'h0);
        check("rst_busy", 32'(Busy), 32'h0);
        check("rst_done", 32'(Done), 32'h0);
        RST = 1'b0;
        @(negedge CLK);

        // Normal sweep, ack two cycles after each request
        ack_mode = 1; ack_dly = 2;
        kw_log.delete(); base_done = n_done; base_hs = n_hs;
        start_sweep(32'h0100_0000, 32'h0010_0000, 16'd4, 24'd5);
        check("t1_kw_first", KW, 32'h0100_0000);
        check("t1_busy_first", 32'(Busy), 32'h1);
        wait_idle("t1_timeout", 200);
        check("t1_nreq", kw_log.size(), 32'd4);
        check("t1_kw0", kw_log[0], 32'h0100_0000);
        check("t1_kw1", kw_log[1], 32'h0110_0000);
        check("t1_kw2", kw_log[2], 32'h0120_0000);
        check("t1_kw3", kw_log[3], 32'h0130_0000);
        check("t1_hs", n_hs - base_hs, 32'd4);
        check("t1_done", n_done - base_done, 32'd1);
        repeat (2) @(negedge CLK);

        // Zero settle, single point, ack tied high
        ack_mode = 2;
        base_done = n_done;
        start_sweep(32'hA5A5_0000, 32'h1, 16'd1, 24'd0);
        check("t2_kw", KW, 32'hA5A5_0000);
        check("t2_req_c1", 32'(Meas_Req), 32'h0);
        @(negedge CLK);
        check("t2_req_c2", 32'(Meas_Req), 32'h1);
        @(negedge CLK);
        check("t2_req_c3", 32'(Meas_Req), 32'h0);
        check("t2_done_c3", 32'(Done), 32'h1);
        check("t2_busy_c3", 32'(Busy), 32'h1);
        @(negedge CLK);
        check("t2_busy_c4", 32'(Busy), 32'h0);
        check("t2_done_c4", 32'(Done), 32'h0);
        check("t2_ndone", n_done - base_done, 32'd1);
        @(negedge CLK);

        // Tuning-word wrap
        ack_mode = 1; ack_dly = 0;
        kw_log.delete();
        start_sweep(32'hFFFF_FFF0, 32'h0000_0020, 16'd2, 24'd1);
        wait_idle("t3_timeout", 100);
        check("t3_nreq", kw_log.size(), 32'd2);
        check("t3_kw0", kw_log[0], 32'hFFFF_FFF0);
        check("t3_kw1", kw_log[1], 32'h0000_0010);
        @(negedge CLK);

        // Abort with a simultaneous ack on the third measurement
        ack_mode = 0;
        base_done = n_done;
        start_sweep(32'h0000_1000, 32'h0000_0100, 16'd5, 24'd2);
        for (int p = 0; p < 3; p++) begin
            wait_req("t4_req_timeout", 50);
            if (p < 2) begin
                man_ack = 1'b1;
                @(negedge CLK);
                man_ack = 1'b0;
            end else begin
                check("t4_kw_pt2", KW, 32'h0000_1200);
                Abort = 1'b1;
                man_ack = 1'b1;
                @(negedge CLK);
                Abort = 1'b0;
                man_ack = 1'b0;
            end
        end
        check("t4_kw", KW, 32'h0);
        check("t4_req", 32'(Meas_Req), 32'h0);
        check("t4_busy", 32'(Busy), 32'h0);
        check("t4_sin", 32'(SW_Sin_Out), 32'h0);
        check("t4_done", 32'(Done), 32'h0);
        repeat (2) @(negedge CLK);
        check("t4_ndone", n_done - base_done, 32'd0);

        // Ignored starts: Abort+Start, Step_Num=0, and Start while busy
        Abort = 1'b1;
        start_sweep(32'h1234_0000, 32'h1, 16'd3, 24'd1);
        Abort = 1'b0;
        check("t5_abort_start", 32'(Busy), 32'h0);
        start_sweep(32'h1234_0000, 32'h1, 16'd0, 24'd1);
        check("t5_zero_steps", 32'(Busy), 32'h0);
        ack_mode = 1; ack_dly = 1;
        kw_log.delete(); base_done = n_done;
        start_sweep(32'h2000_0000, 32'h0300_0000, 16'd3, 24'd3);
        @(negedge CLK);
        start_sweep(32'hDEAD_BEEF, 32'h0000_0001, 16'd9, 24'd0);
        wait_idle("t5_timeout", 200);
        check("t5_nreq", kw_log.size(), 32'd3);
        check("t5_kw0", kw_log[0], 32'h2000_0000);
        check("t5_kw2", kw_log[2], 32'h2600_0000);
        check("t5_ndone", n_done - base_done, 32'd1);
        @(negedge CLK);

        // Asynchronous reset in the middle of a settle
        base_done = n_done;
        start_sweep(32'h4000_0000, 32'h1, 16'd2, 24'd20);
        repeat (3) @(negedge CLK);
        check("t6_busy_pre", 32'(Busy), 32'h1);
        #2 RST = 1'b1;
        #1;
        check("t6_kw", KW, 32'h0);
        check("t6_busy", 32'(Busy), 32'h0);
        check("t6_sin", 32'(SW_Sin_Out), 32'h0);
        check("t6_req", 32'(Meas_Req), 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("t6_idle", 32'(Busy), 32'h0);
        check("t6_ndone", n_done - base_done, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
